// File: rtl/fetch_align_buffer.sv
// Halfword alignment queue between fetch and decode: reassembles split 32-bit
// instructions and expands RV32C. Define FETCH_ALIGN_ILLEGAL_EN to drive illegal_o.
module fetch_align_buffer #(
    parameter int unsigned DEPTH_HW = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_data_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        flush_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_comp_o,
    output logic        illegal_o
);
    localparam int unsigned AW = $clog2(DEPTH_HW);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH_HW);

    logic [15:0]   mem [DEPTH_HW];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic [31:0]   head_pc;
    logic          need_pc;

    logic [15:0] hw0, hw1;
    logic        is_comp, avail, accept, pop;
    logic [1:0]  push_n, pop_n;
    logic [31:0] expanded;

    function automatic logic [31:0] expand(input logic [15:0] c);
        logic [4:0]  rd, rs2, rdp, rs1p;
        logic [11:0] jo;
        logic [8:0]  bo;
        logic [31:0] r;
        rd   = c[11:7];
        rs2  = c[6:2];
        rdp  = {2'b01, c[4:2]};
        rs1p = {2'b01, c[9:7]};
        jo   = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
        bo   = {c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};
        r    = 32'd3;
        case ({c[1:0], c[15:13]})
            5'b00_000: if ({c[12:5]} != '0)
                r = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, 7'h13};
            5'b00_010: r = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, 7'h03};
            5'b00_110: r = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, 7'h23};
            5'b01_000: r = {{7{c[12]}}, c[6:2], rd, 3'b000, rd, 7'h13};
            5'b01_001, 5'b01_101:
                r = {jo[11], jo[10:1], jo[11], {8{jo[11]}}, (c[15] ? 5'd0 : 5'd1), 7'h6f};
            5'b01_010: r = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, rd, 7'h13};
            5'b01_011: begin
                if (rd == 5'd2) begin
                    if ({c[12], c[6:2]} != '0)
                        r = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, 7'h13};
                end else if ({c[12], c[6:2]} != '0) begin
                    r = {{15{c[12]}}, c[6:2], rd, 7'h37};
                end
            end
            5'b01_100: case (c[11:10])
                2'b00: if (!c[12]) r = {7'b0, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                2'b01: if (!c[12]) r = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, 7'h13};
                2'b10: r = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, 7'h13};
                default: if (!c[12]) begin
                    case (c[6:5])
                        2'b00:   r = {7'b0100000, rdp, rs1p, 3'b000, rs1p, 7'h33};
                        2'b01:   r = {7'b0, rdp, rs1p, 3'b100, rs1p, 7'h33};
                        2'b10:   r = {7'b0, rdp, rs1p, 3'b110, rs1p, 7'h33};
                        default: r = {7'b0, rdp, rs1p, 3'b111, rs1p, 7'h33};
                    endcase
                end
            endcase
            5'b01_110, 5'b01_111:
                r = {bo[8], {2{bo[8]}}, bo[8:5], 5'd0, rs1p, 2'b00, c[13], bo[4:1], bo[8], 7'h63};
            5'b10_000: if (!c[12]) r = {7'b0, c[6:2], rd, 3'b001, rd, 7'h13};
            5'b10_010: if (rd != '0)
                r = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, rd, 7'h03};
            5'b10_100: begin
                if (!c[12]) begin
                    if (rs2 == '0) begin
                        if (rd != '0) r = {12'b0, rd, 3'b000, 5'd0, 7'h67};
                    end else begin
                        r = {7'b0, rs2, 5'd0, 3'b000, rd, 7'h33};
                    end
                end else if (rs2 == '0 && rd == '0) begin
                    r = 32'h0010_0073;
                end else if (rs2 == '0) begin
                    r = {12'b0, rd, 3'b000, 5'd1, 7'h67};
                end else begin
                    r = {7'b0, rs2, rd, 3'b000, rd, 7'h33};
                end
            end
            5'b10_110: r = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010, c[11:9], 2'b00, 7'h23};
            default: r = 32'd3;
        endcase
        return r;
    endfunction

    assign hw0      = mem[head];
    assign hw1      = mem[head + AW'(1)];
    assign is_comp  = hw0[1:0] != 2'b11;
    assign avail    = is_comp ? (count != '0) : (count >= (AW+1)'(2));
    assign expanded = expand(hw0);

    assign fetch_ready_o = !flush_i && ((DEPTH_CNT - count) >= (AW+1)'(2));
    assign inst_valid_o  = avail && !flush_i;
    assign inst_o        = !avail ? 32'h0000_0013 : (is_comp ? expanded : {hw1, hw0});
    assign inst_comp_o   = avail && is_comp;
    assign inst_pc_o     = head_pc;

`ifdef FETCH_ALIGN_ILLEGAL_EN
    assign illegal_o = inst_valid_o && is_comp && (hw0 == '0 || expanded == 32'd3);
`else
    assign illegal_o = 1'b0;
`endif

    assign accept = fetch_valid_i && fetch_ready_o;
    assign push_n = !accept ? 2'd0 : (fetch_pc_i[1] ? 2'd1 : 2'd2);
    assign pop    = inst_valid_o && inst_ready_i;
    assign pop_n  = !pop ? 2'd0 : (is_comp ? 2'd1 : 2'd2);

    always_ff @(posedge clk) begin
        if (accept) begin
            if (fetch_pc_i[1]) begin
                mem[tail] <= fetch_data_i[31:16];
            end else begin
                mem[tail]          <= fetch_data_i[15:0];
                mem[tail + AW'(1)] <= fetch_data_i[31:16];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            head    <= '0;
            tail    <= '0;
            head_pc <= RESET_PC;
            need_pc <= 1'b1;
        end else if (flush_i) begin
            count   <= '0;
            head    <= '0;
            tail    <= '0;
            need_pc <= 1'b1;
        end else begin
            count <= count + (AW+1)'(push_n) - (AW+1)'(pop_n);
            tail  <= tail + AW'(push_n);
            head  <= head + AW'(pop_n);
            if (pop)
                head_pc <= head_pc + (is_comp ? 32'd2 : 32'd4);
            // need_pc implies an empty buffer, so capture never races a pop
            if (accept && need_pc) begin
                head_pc <= fetch_pc_i;
                need_pc <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_align_buffer.sv
// Bench for fetch_align_buffer: halfword-queue reference model with an RV32C
// decoder built from immediate fields and generic encoders, plus directed literals.
module tb_fetch_align_buffer;
    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] RPC = 32'h0000_1000;
`ifdef FETCH_ALIGN_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_valid_i = 1'b0;
    logic        fetch_ready_o;
    logic [31:0] fetch_data_i = '0;
    logic [31:0] fetch_pc_i = '0;
    logic        flush_i = 1'b0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_comp_o;
    logic        illegal_o;

    fetch_align_buffer #(.DEPTH_HW(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst),
        .fetch_valid_i(fetch_valid_i), .fetch_ready_o(fetch_ready_o),
        .fetch_data_i(fetch_data_i), .fetch_pc_i(fetch_pc_i), .flush_i(flush_i),
        .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_comp_o(inst_comp_o),
        .illegal_o(illegal_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [15:0] q[$];
    logic [31:0] m_pc;
    bit          m_need;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sx(input logic [31:0] v, input int b);
        for (int i = b + 1; i < 32; i++) v[i] = v[b];
        return v;
    endfunction
    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] m_expand(input logic [15:0] c);
        logic [31:0] imm, r, i6;
        logic [4:0]  rd, rs2, rdp, rs1p;
        imm  = '0;
        r    = 32'd3;
        rd   = c[11:7];
        rs2  = c[6:2];
        rdp  = 5'd8 + 5'(c[4:2]);
        rs1p = 5'd8 + 5'(c[9:7]);
        i6   = sx({26'b0, c[12], c[6:2]}, 5);
        case (c[1:0])
            2'b00: case (c[15:13])
                3'b000: begin
                    imm[5:4] = c[12:11]; imm[9:6] = c[10:7]; imm[3] = c[5]; imm[2] = c[6];
                    if (imm != 0) r = enc_i(imm, 5'd2, 3'd0, rdp, 7'h13);
                end
                3'b010: begin
                    imm[5:3] = c[12:10]; imm[6] = c[5]; imm[2] = c[6];
                    r = enc_i(imm, rs1p, 3'd2, rdp, 7'h03);
                end
                3'b110: begin
                    imm[5:3] = c[12:10]; imm[6] = c[5]; imm[2] = c[6];
                    r = enc_s(imm, rdp, rs1p, 3'd2);
                end
                default: ;
            endcase
            2'b01: case (c[15:13])
                3'b000: r = enc_i(i6, rd, 3'd0, rd, 7'h13);
                3'b001, 3'b101: begin
                    imm[11] = c[12]; imm[4] = c[11]; imm[9:8] = c[10:9]; imm[10] = c[8];
                    imm[6] = c[7]; imm[7] = c[6]; imm[3:1] = c[5:3]; imm[5] = c[2];
                    r = enc_j(sx(imm, 11), c[15] ? 5'd0 : 5'd1);
                end
                3'b010: r = enc_i(i6, 5'd0, 3'd0, rd, 7'h13);
                3'b011: begin
                    if (rd == 5'd2) begin
                        imm[9] = c[12]; imm[4] = c[6]; imm[6] = c[5]; imm[8:7] = c[4:3]; imm[5] = c[2];
                        if (imm != 0) r = enc_i(sx(imm, 9), 5'd2, 3'd0, 5'd2, 7'h13);
                    end else if (i6 != 0) begin
                        imm = i6 << 12;
                        r = {imm[31:12], rd, 7'h37};
                    end
                end
                3'b100: case (c[11:10])
                    2'b00: if (!c[12]) r = enc_i({27'b0, c[6:2]}, rs1p, 3'd5, rs1p, 7'h13);
                    2'b01: if (!c[12]) r = enc_i(32'h400 | {27'b0, c[6:2]}, rs1p, 3'd5, rs1p, 7'h13);
                    2'b10: r = enc_i(i6, rs1p, 3'd7, rs1p, 7'h13);
                    default: if (!c[12]) begin
                        case (c[6:5])
                            2'b00:   r = enc_r(7'h20, rdp, rs1p, 3'd0, rs1p);
                            2'b01:   r = enc_r(7'h00, rdp, rs1p, 3'd4, rs1p);
                            2'b10:   r = enc_r(7'h00, rdp, rs1p, 3'd6, rs1p);
                            default: r = enc_r(7'h00, rdp, rs1p, 3'd7, rs1p);
                        endcase
                    end
                endcase
                default: begin
                    imm[8] = c[12]; imm[4:3] = c[11:10]; imm[7:6] = c[6:5]; imm[2:1] = c[4:3]; imm[5] = c[2];
                    r = enc_b(sx(imm, 8), 5'd0, rs1p, c[13] ? 3'd1 : 3'd0);
                end
            endcase
            2'b10: case (c[15:13])
                3'b000: if (!c[12]) r = enc_i({27'b0, c[6:2]}, rd, 3'd1, rd, 7'h13);
                3'b010: if (rd != 0) begin
                    imm[5] = c[12]; imm[4:2] = c[6:4]; imm[7:6] = c[3:2];
                    r = enc_i(imm, 5'd2, 3'd2, rd, 7'h03);
                end
                3'b100: begin
                    if (!c[12] && rs2 == 0) begin
                        if (rd != 0) r = enc_i(32'd0, rd, 3'd0, 5'd0, 7'h67);
                    end else if (!c[12]) r = enc_r(7'h00, rs2, 5'd0, 3'd0, rd);
                    else if (rs2 == 0 && rd == 0) r = 32'h0010_0073;
                    else if (rs2 == 0) r = enc_i(32'd0, rd, 3'd0, 5'd1, 7'h67);
                    else r = enc_r(7'h00, rs2, rd, 3'd0, rd);
                end
                3'b110: begin
                    imm[5:2] = c[12:9]; imm[7:6] = c[8:7];
                    r = enc_s(imm, rs2, 5'd2, 3'd2);
                end
                default: ;
            endcase
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = $urandom;
        p[0] = 1'b0;
        return p;
    endfunction

    // One cycle: drive at negedge, compare against the model, advance the model,
    // then return just after the posedge with fetch/flush released.
    task automatic step(input bit fv, input logic [31:0] fd, input logic [31:0] fpc,
                        input bit fl, input bit rdy);
        bit er, ev, ec, ei;
        logic [31:0] ex;
        @(negedge clk);
        fetch_valid_i = fv; fetch_data_i = fd; fetch_pc_i = fpc; flush_i = fl; inst_ready_i = rdy;
        #1;
        er = !fl && (int'(DEPTH) - q.size() >= 2);
        ev = 0; ec = 0; ei = 0; ex = '0;
        if (q.size() >= 1 && q[0][1:0] != 2'b11) begin
            ev = 1; ec = 1; ex = m_expand(q[0]);
            ei = ILL_EN && (q[0] == 16'h0000 || ex == 32'd3);
        end else if (q.size() >= 2) begin
            ev = 1; ex = {q[1], q[0]};
        end
        if (fl) ev = 0;
        check("fetch_ready", {31'b0, fetch_ready_o}, {31'b0, er});
        check("inst_valid", {31'b0, inst_valid_o}, {31'b0, ev});
        if (ev) begin
            check("inst", inst_o, ex);
            check("inst_pc", inst_pc_o, m_pc);
            check("inst_comp", {31'b0, inst_comp_o}, {31'b0, ec});
            check("illegal", {31'b0, illegal_o}, {31'b0, ei});
        end
        if (fl) begin
            q.delete();
            m_need = 1;
        end else begin
            if (ev && rdy) begin
                void'(q.pop_front());
                if (!ec) void'(q.pop_front());
                m_pc += ec ? 32'd2 : 32'd4;
            end
            if (fv && er) begin
                if (m_need) begin m_pc = fpc; m_need = 0; end
                if (fpc[1]) q.push_back(fd[31:16]);
                else begin q.push_back(fd[15:0]); q.push_back(fd[31:16]); end
            end
        end
        @(posedge clk);
        #1;
        fetch_valid_i = 0; flush_i = 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", {31'b0, inst_valid_o}, 32'd0);
        check("rst_ready", {31'b0, fetch_ready_o}, 32'd1);
        check("rst_inst", inst_o, 32'h0000_0013);
        check("rst_pc", inst_pc_o, RPC);
        check("rst_comp", {31'b0, inst_comp_o}, 32'd0);
        check("rst_illegal", {31'b0, illegal_o}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        fetch_valid_i = 0; flush_i = 0;
        #3 rst = 1;
        #1 check_reset_outputs();
        q.delete(); m_pc = RPC; m_need = 1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        logic [31:0] fpc_next;
        m_pc = RPC; m_need = 1;
        #1 rst = 1;
        @(negedge clk);
        @(negedge clk);
        #1 check_reset_outputs();
        rst = 0;

        // two compressed instructions in one word
        step(1, 32'h4515_0001, 32'h100, 0, 1);
        check("t1_inst0", inst_o, 32'h0000_0013);
        check("t1_pc0", inst_pc_o, 32'h100);
        check("t1_comp0", {31'b0, inst_comp_o}, 32'd1);
        step(0, 0, 0, 0, 1);
        check("t1_inst1", inst_o, 32'h0050_0513);
        check("t1_pc1", inst_pc_o, 32'h102);
        step(0, 0, 0, 0, 1);
        check("t1_empty", {31'b0, inst_valid_o}, 32'd0);

        // 32-bit instruction split across two fetch words
        step(0, 0, 0, 1, 0);
        step(1, 32'h0513_0001, 32'h200, 0, 1);
        check("t2_nop_pc", inst_pc_o, 32'h200);
        step(0, 0, 0, 0, 1);
        check("t2_partial_wait", {31'b0, inst_valid_o}, 32'd0);
        step(0, 0, 0, 0, 1);
        check("t2_partial_hold", {31'b0, inst_valid_o}, 32'd0);
        step(1, 32'h0001_0050, 32'h204, 0, 1);
        check("t2_span_inst", inst_o, 32'h0050_0513);
        check("t2_span_pc", inst_pc_o, 32'h202);
        check("t2_span_comp", {31'b0, inst_comp_o}, 32'd0);
        step(0, 0, 0, 0, 1);
        check("t2_tail_inst", inst_o, 32'h0000_0013);
        check("t2_tail_pc", inst_pc_o, 32'h206);
        step(0, 0, 0, 0, 1);

        // misaligned redirect target
        step(0, 0, 0, 1, 0);
        step(1, 32'h4515_abcd, 32'h302, 0, 0);
        check("t3_inst", inst_o, 32'h0050_0513);
        check("t3_pc", inst_pc_o, 32'h302);
        step(0, 0, 0, 0, 1);
        check("t3_empty", {31'b0, inst_valid_o}, 32'd0);

        // backpressure until full, then drain
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h0050_0513, 32'h500 + 32'(i * 4), 0, 0);
            check("t4_ready_fill", {31'b0, fetch_ready_o}, (i == 3) ? 32'd0 : 32'd1);
        end
        step(1, 32'h0050_0513, 32'h510, 0, 1);
        check("t4_ready_back", {31'b0, fetch_ready_o}, 32'd1);
        check("t4_pc", inst_pc_o, 32'h504);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
        check("t4_drained", {31'b0, inst_valid_o}, 32'd0);

        // flush with three halfwords buffered and a fetch pending
        step(0, 0, 0, 1, 0);
        step(1, 32'h0001_0001, 32'h600, 0, 0);
        step(1, 32'h0001_0001, 32'h606, 0, 0);
        check("t5_before", {31'b0, inst_valid_o}, 32'd1);
        step(1, 32'h0001_0001, 32'h608, 1, 1);
        check("t5_after", {31'b0, inst_valid_o}, 32'd0);
        step(1, 32'h0001_0001, 32'h400, 0, 0);
        check("t5_pc", inst_pc_o, 32'h400);
        check("t5_valid", {31'b0, inst_valid_o}, 32'd1);

        // all-zero halfwords
        step(0, 0, 0, 1, 0);
        step(1, 32'h0000_0000, 32'h700, 0, 0);
        check("t6_inst0", inst_o, 32'd3);
        check("t6_ill0", {31'b0, illegal_o}, {31'b0, ILL_EN});
        step(0, 0, 0, 0, 1);
        check("t6_inst1", inst_o, 32'd3);
        check("t6_pc1", inst_pc_o, 32'h702);
        check("t6_ill1", {31'b0, illegal_o}, {31'b0, ILL_EN});
        step(0, 0, 0, 0, 1);

        // randomized traffic with redirects and occasional mid-stream resets
        step(0, 0, 0, 1, 0);
        fpc_next = rand_pc();
        for (int n = 0; n < 4000; n++) begin
            bit fl, fv, rdy, acc;
            logic [31:0] fd, fpc;
            if (n % 1000 == 999) begin
                do_reset();
                fpc_next = rand_pc();
            end
            fl  = ($urandom_range(0, 47) == 0);
            fv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            fd  = $urandom;
            fpc = fpc_next;
            acc = fv && !fl && (int'(DEPTH) - q.size() >= 2);
            step(fv, fd, fpc, fl, rdy);
            if (fl) fpc_next = rand_pc();
            else if (acc) fpc_next = {fpc[31:2], 2'b00} + 32'd4;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_align_buffer.md
Name: fetch_align_buffer

Overview:
- Parametrised instruction-alignment queue between the instruction fetch port and decode, for mixed RV32I/RV32C streams.
- Accepts 32-bit fetch words, which may start on a halfword boundary, into a halfword FIFO.
- Reassembles 32-bit instructions that span two fetch words and expands 16-bit instructions to RV32I.
- Presents one 32-bit instruction per cycle to decode, with PC and compressed flag, under valid/ready handshakes on both sides.

Parameters:
- DEPTH_HW, 8, buffer capacity in halfwords; power of 2, minimum 4.
- RESET_PC, 32'h0000_0000, head PC after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- fetch_valid_i  input  1  fetch word present.
- fetch_ready_o  output  1  buffer can accept a fetch word this cycle.
- fetch_data_i  input  32  fetch word; [15:0] = lower halfword.
- fetch_pc_i  input  32  address of fetch_data_i[15:0]; bit 1 set = start at upper halfword.
- flush_i  input  1  redirect: discard buffered contents.
- inst_valid_o  output  1  complete instruction available.
- inst_ready_i  input  1  decode consumes instruction.
- inst_o  output  32  RV32I instruction (expanded if compressed).
- inst_pc_o  output  32  PC of inst_o.
- inst_comp_o  output  1  inst_o came from a 16-bit encoding.
- illegal_o  output  1  see Optional Feature.

Behaviour:
- Storage: circular array of DEPTH_HW halfwords with head pointer, tail pointer and count (0..DEPTH_HW).
  - Pointers wrap modulo DEPTH_HW.
- Reset (asynchronous): count=0, pointers=0, head_pc=RESET_PC, need_pc=1.
  - Outputs: inst_valid_o=0, illegal_o=0, fetch_ready_o=1 (unless flush_i), inst_o=32'h0000_0013, inst_pc_o=RESET_PC, inst_comp_o=0.
- fetch_ready_o = !flush_i && (DEPTH_HW - count >= 2), evaluated on the current count; a same-cycle pop is not credited.
- Fetch accept (fetch_valid_i && fetch_ready_o):
  - fetch_pc_i[1]=0: enqueue [15:0] then [31:16] (+2).
  - fetch_pc_i[1]=1: enqueue [31:16] only (+1).
- PC capture: if need_pc=1 at accept, head_pc <= fetch_pc_i and need_pc <= 0. Otherwise fetch_pc_i is ignored; fetch is assumed sequential.
- Head decode is combinational from buffered state, so an accepted word is visible at the outputs the cycle after accept.
  - Head halfword bits[1:0]!=2'b11: compressed. inst_valid_o = (count>=1); inst_o = RV32C expansion of the head halfword; inst_comp_o=1.
  - Otherwise: 32-bit. inst_valid_o = (count>=2); inst_o = {hw[head+1], hw[head]}; inst_comp_o=0.
  - A 32-bit instruction with count==1 waits; the partial halfword is retained across cycles.
- inst_pc_o = head_pc. Outputs are undefined when inst_valid_o=0; the bench must not check them then.
- Pop (inst_valid_o && inst_ready_i): head advances 1 (compressed) or 2 (32-bit); head_pc += 2 or 4.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped.
- RV32C expansion: all quadrant 0/1/2 RV32C forms.
  - Unsupported or reserved encodings expand to 32'd3.
  - c.nop 0x0001 -> 0x0000_0013.
- flush_i (synchronous, priority over everything):
  - count <= 0, head/tail <= 0, need_pc <= 1.
  - Fetch data in the same cycle is dropped (fetch_ready_o=0).
  - No pop occurs; inst_valid_o is forced 0 in the flush cycle.
- Reset asserted mid-stream: the buffer empties immediately; the partial 32-bit instruction is lost.

Optional Feature:
- Macro: FETCH_ALIGN_ILLEGAL_EN.
- Defined:
  - illegal_o = inst_valid_o && inst_comp_o && (head halfword==16'h0000 || expansion==32'd3).
  - The instruction is still presented and popped normally; illegal_o is for the trap logic only.
- Undefined: illegal_o tied to 0; the detection logic is not synthesised.

Test Plan:
- Reset, then fetch 0x4515_0001 @pc 0x100, inst_ready_i=1:
  - Cycle 1: inst_o=0x0000_0013, pc 0x100, comp=1.
  - Cycle 2: inst_o=0x0050_0513, pc 0x102, comp=1.
  - Then inst_valid_o=0.
- Spanning 32-bit instruction:
  - Fetch 0x0513_0001 @0x200: nop @0x200 out; then inst_valid_o stays 0 while only 0x0513 is buffered.
  - Fetch 0x0001_0050: inst_o=0x0050_0513 @0x202, comp=0; then nop @0x206.
- Misaligned start: fetch 0x4515_xxxx @pc 0x302 -> only the upper halfword is enqueued; inst_o=0x0050_0513, pc 0x302.
- Backpressure with DEPTH_HW=8, inst_ready_i=0, four 32-bit words pushed:
  - fetch_ready_o drops after the 4th accept (count=8).
  - Raising inst_ready_i pops one 32-bit instruction per cycle; fetch_ready_o reasserts the cycle after count<=6.
- Flush with count=3 and a concurrent fetch_valid_i:
  - Next cycle count=0, inst_valid_o=0.
  - The following fetch @0x400 sets inst_pc_o=0x400.
- FETCH_ALIGN_ILLEGAL_EN defined, fetch 0x0000_0000:
  - illegal_o=1 with inst_o=32'd3 for two consecutive pops.
  - With the macro undefined, illegal_o=0 throughout.
